// File: rtl/gat_feat_rd_pkg.sv
// Shared types and derived constants for the GAT final-feature readback stage.
package gat_feat_rd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } rd_state_e;

    localparam int unsigned BramRdLatDefault = 2;

    // Two spare entries beyond the read pipeline keep reads flowing at one per cycle.
    function automatic int unsigned fifo_depth(input int unsigned rd_lat);
        return rd_lat + 2;
    endfunction

endpackage

// File: rtl/gat_feat_reader_if.sv
// AXI-Stream style feature beat bus between the readback stage and the DMA/host path.
interface gat_feat_reader_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/gat_feat_rd_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and occupancy count.
module gat_feat_rd_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrLast) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/gat_feat_reader.sv
// Sweeps the GAT new-feature BRAM after each gat_ready rising edge and streams every word out.
// Build option GAT_FEAT_RD_ROW_LAST_EN: tlast marks the end of every node row, not only the frame.
module gat_feat_reader
    import gat_feat_rd_pkg::*;
#(
    parameter int unsigned NEW_FEATURE_WIDTH  = 32,
    parameter int unsigned NUM_SUBGRAPHS      = 2708,
    parameter int unsigned NUM_FEATURE_OUT    = 16,
    parameter int unsigned BRAM_RD_LAT        = BramRdLatDefault,
    parameter int unsigned NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int unsigned NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int unsigned FIFO_DEPTH         = fifo_depth(BRAM_RD_LAT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          gat_ready,
    output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
    gat_feat_reader_if.master             m_axis,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned AW    = NEW_FEATURE_ADDR_W;
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned InflW = $clog2(BRAM_RD_LAT + 2);
    localparam logic [AW-1:0] LastAddr = AW'(NEW_FEATURE_DEPTH - 1);

    rd_state_e              state_q;
    logic                   gat_ready_q;
    logic [AW-1:0]          word_addr_q;
    logic [AW-1:0]          beat_idx_q;
    logic                   busy_q, done_q;
    logic [BRAM_RD_LAT:0]   rd_sr_q;
    logic [InflW-1:0]       inflight;
    logic [CntW-1:0]        fifo_count;
    logic [NEW_FEATURE_WIDTH:0] fifo_rdata;
    logic                   rise, grant, credit_ok, push, pop, push_last, frame_last_pop;

    assign rise = gat_ready & ~gat_ready_q;
    assign push = rd_sr_q[BRAM_RD_LAT];
    assign pop  = m_axis.tvalid & m_axis.tready;
    assign frame_last_pop = pop && (beat_idx_q == LastAddr);

    // Bit 0 is a granted read whose address goes out next cycle; the top bit is data arriving.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= BRAM_RD_LAT; i++) inflight = inflight + InflW'(rd_sr_q[i]);
    end

    // A beat leaving this cycle frees its slot, which sustains one beat per cycle.
    assign credit_ok = (32'(fifo_count) + 32'(inflight)) < (32'(FIFO_DEPTH) + 32'(pop));

    // The grant for word 0 comes with the edge; later grants advance the address one ahead.
    always_comb begin
        grant = 1'b0;
        unique case (state_q)
            StIdle:  grant = rise;
            StRun:   grant = credit_ok && (word_addr_q != LastAddr);
            default: grant = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            word_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    word_addr_q <= '0;
                    if (rise) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                    end
                end
                StRun: begin
                    if (word_addr_q == LastAddr) begin
                        state_q <= StDrain;
                    end else if (grant) begin
                        word_addr_q <= word_addr_q + 1'b1;
                    end
                end
                StDrain: begin
                    if (frame_last_pop) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q     <= StIdle;
                    word_addr_q <= '0;
                    done_q      <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gat_ready_q <= 1'b0;
            rd_sr_q     <= '0;
            beat_idx_q  <= '0;
        end else begin
            gat_ready_q <= gat_ready;
            rd_sr_q     <= {rd_sr_q[BRAM_RD_LAT-1:0], grant};
            if (state_q == StDone) beat_idx_q <= '0;
            else if (pop)          beat_idx_q <= beat_idx_q + 1'b1;
        end
    end

`ifdef GAT_FEAT_RD_ROW_LAST_EN
    localparam int unsigned ColW = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
    localparam logic [ColW-1:0] ColLast = ColW'(NUM_FEATURE_OUT - 1);

    logic [ColW-1:0] col_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    col_q <= '0;
        else if (state_q == StDone) col_q <= '0;
        else if (push)              col_q <= (col_q == ColLast) ? '0 : col_q + 1'b1;
    end

    assign push_last = (col_q == ColLast);
`else
    logic [AW-1:0] push_idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    push_idx_q <= '0;
        else if (state_q == StDone) push_idx_q <= '0;
        else if (push)              push_idx_q <= push_idx_q + 1'b1;
    end

    assign push_last = (push_idx_q == LastAddr);
`endif

    gat_feat_rd_fifo #(
        .WIDTH (NEW_FEATURE_WIDTH + 1),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CntW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({push_last, feat_bram_dout}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    assign feat_bram_addrb = {word_addr_q, 2'b00};
    assign m_axis.tdata    = fifo_rdata[NEW_FEATURE_WIDTH-1:0];
    assign m_axis.tlast    = fifo_rdata[NEW_FEATURE_WIDTH];
    assign m_axis.tvalid   = (fifo_count != '0);
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_gat_feat_reader.sv
// Bench for gat_feat_reader: 2 rows x 4 features, BRAM model returns the word index.
module tb_gat_feat_reader;

    localparam int unsigned W     = 32;
    localparam int unsigned NS    = 2;
    localparam int unsigned NFO   = 4;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = NS * NFO;
    localparam int unsigned AW    = $clog2(DEPTH);
`ifdef GAT_FEAT_RD_ROW_LAST_EN
    localparam int LASTS = NS;
`else
    localparam int LASTS = 1;
`endif

    typedef struct {
        string name;
        int    ready_mode;   // 0 always ready, 1 every other cycle, 2 every third cycle
        int    stall;        // cycles of tready low right after the edge
        bit    hold;         // keep gat_ready high after the edge
        int    exp_beats;
        int    exp_first_valid;
        int    exp_max_addr;
        int    exp_lasts;
        int    exp_stall_addr;
    } vec_t;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          gat_ready;
    logic [AW+1:0] addrb;
    logic [W-1:0]  dout;
    logic          busy, done;

    gat_feat_reader_if #(.WIDTH(W)) axis ();

    gat_feat_reader #(
        .NEW_FEATURE_WIDTH (W),
        .NUM_SUBGRAPHS     (NS),
        .NUM_FEATURE_OUT   (NFO),
        .BRAM_RD_LAT       (LAT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .gat_ready       (gat_ready),
        .feat_bram_addrb (addrb),
        .feat_bram_dout  (dout),
        .m_axis          (axis),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // BRAM model: data for an address appears LAT cycles later and equals the word index.
    logic [AW+1:0] apipe [LAT];
    always @(posedge clk) begin
        apipe[0] <= addrb;
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign dout = W'(apipe[LAT-1] >> 2);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    checks = 0, failures = 0;
    beat_t expq[$];
    beat_t mon_e;
    bit    armed = 0;
    int    t0, first_valid, max_addr, done_pulses, beats, lasts, last_beat_cyc, done_cyc;
    bit    prev_stall = 0, prev_last;
    logic [W-1:0] prev_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_last(input int i);
`ifdef GAT_FEAT_RD_ROW_LAST_EN
        return (i % NFO) == (NFO - 1);
`else
        return i == DEPTH - 1;
`endif
    endfunction

    function automatic logic ready_for(input vec_t v, input int k);
        if (k < v.stall) return 1'b0;
        case (v.ready_mode)
            1:       return (k % 2) == 0;
            2:       return (k % 3) == 0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic clear_metrics();
        first_valid = -1; max_addr = 0; done_pulses = 0; beats = 0; lasts = 0;
        last_beat_cyc = -1; done_cyc = -1;
    endtask

    task automatic push_frame();
        beat_t b;
        for (int i = 0; i < DEPTH; i++) begin
            b.data = W'(i);
            b.last = exp_last(i);
            expq.push_back(b);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addrb"},  64'(addrb),       64'd0);
        check({tag, "_tdata"},  64'(axis.tdata),  64'd0);
        check({tag, "_tvalid"}, 64'(axis.tvalid), 64'd0);
        check({tag, "_tlast"},  64'(axis.tlast),  64'd0);
        check({tag, "_busy"},   64'(busy),        64'd0);
        check({tag, "_done"},   64'(done),        64'd0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (armed) begin
                if (axis.tvalid && first_valid < 0) first_valid = cyc - t0;
                if (int'(addrb) > max_addr) max_addr = int'(addrb);
            end
            if (done) begin
                done_pulses++;
                done_cyc = cyc;
            end
            if (prev_stall)
                check("stall_hold", {axis.tlast, axis.tvalid, axis.tdata},
                      {prev_last, 1'b1, prev_data});
            if (axis.tvalid && axis.tready) begin
                beats++;
                last_beat_cyc = cyc;
                if (axis.tlast) lasts++;
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL beat_unexpected: got data %0h, expected no beat", axis.tdata);
                end else begin
                    mon_e = expq.pop_front();
                    check("beat_data", 64'(axis.tdata), 64'(mon_e.data));
                    check("beat_last", 64'(axis.tlast), 64'(mon_e.last));
                end
            end
            prev_stall = axis.tvalid && !axis.tready;
            prev_data  = axis.tdata;
            prev_last  = axis.tlast;
        end
    end

    task automatic run_frame(input vec_t v);
        int k;
        bit got_done;
        clear_metrics();
        push_frame();
        @(posedge clk);
        #1;
        t0 = cyc;
        armed = 1;
        gat_ready = 1'b1;
        axis.tready = ready_for(v, 0);
        k = 0;
        got_done = 0;
        while (k < 400 && !got_done) begin
            @(posedge clk);
            #1;
            k++;
            if (!v.hold) gat_ready = 1'b0;
            if (v.stall > 0 && k == v.stall) begin
                check({v.name, "_stall_addrb"},  64'(addrb),       64'(v.exp_stall_addr));
                check({v.name, "_stall_tvalid"}, 64'(axis.tvalid), 64'd1);
                check({v.name, "_stall_tdata"},  64'(axis.tdata),  64'd0);
            end
            axis.tready = ready_for(v, k);
            got_done = (done_pulses > 0);
        end
        check({v.name, "_timeout"}, 64'(got_done), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        armed = 0;
        check({v.name, "_beats"},       64'(beats),         64'(v.exp_beats));
        check({v.name, "_first_valid"}, 64'(first_valid),   64'(v.exp_first_valid));
        check({v.name, "_max_addrb"},   64'(max_addr),      64'(v.exp_max_addr));
        check({v.name, "_lasts"},       64'(lasts),         64'(v.exp_lasts));
        check({v.name, "_done_pulses"}, 64'(done_pulses),   64'd1);
        check({v.name, "_done_cycle"},  64'(done_cyc),      64'(last_beat_cyc + 1));
        check({v.name, "_busy_after"},  64'(busy),          64'd0);
        check({v.name, "_queue_empty"}, 64'(expq.size()),   64'd0);
        axis.tready = 1'b1;
    endtask

    vec_t vecs[4];
    vec_t hold_vec;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        vecs[0] = '{"full_rate",   0, 0,  0, DEPTH, LAT + 2, (DEPTH - 1) * 4, LASTS, 0};
        vecs[1] = '{"alt_ready",   1, 0,  0, DEPTH, LAT + 2, (DEPTH - 1) * 4, LASTS, 0};
        vecs[2] = '{"third_ready", 2, 0,  0, DEPTH, LAT + 2, (DEPTH - 1) * 4, LASTS, 0};
        vecs[3] = '{"stall20",     0, 20, 0, DEPTH, LAT + 2, (DEPTH - 1) * 4, LASTS,
                    (LAT + 2 - 1) * 4};
        hold_vec = '{"hold_high",  0, 0,  1, DEPTH, LAT + 2, (DEPTH - 1) * 4, LASTS, 0};

        rst = 1'b1;
        gat_ready = 1'b0;
        axis.tready = 1'b1;
        #1;
        check_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_zero("post_reset");

        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        // gat_ready left high across DONE must not start another frame.
        run_frame(hold_vec);
        clear_metrics();
        repeat (20) @(posedge clk);
        #1;
        check("retrig_no_beats", 64'(beats), 64'd0);
        check("retrig_no_done",  64'(done_pulses), 64'd0);
        check("retrig_idle",     64'(busy), 64'd0);
        gat_ready = 1'b0;
        @(posedge clk);
        #1;
        run_frame(vecs[0]);

        // Reset in the middle of a frame, after beat 3 is accepted.
        clear_metrics();
        push_frame();
        gat_ready = 1'b1;
        @(posedge clk);
        #1;
        gat_ready = 1'b0;
        k = 0;
        while (k < 50 && beats < 4) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("midrst_reach_beat3", 64'(beats), 64'd4);
        rst = 1'b1;
        #1;
        expq.delete();
        check_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_metrics();
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_beats", 64'(beats), 64'd0);
        check_zero("midrst_idle");
        run_frame(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
